// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller state encoding, the forwarding select codes and the zero-register helper.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ABORT    = 2'd2
    } ctrl_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Register 0 is hard-wired, so a match against it is never a dependency.
    function automatic logic reg_match(input logic [4:0] dest, input logic [4:0] src);
        return (dest != REG_ZERO) && (dest == src);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational register comparators: load-use detection and per-operand forwarding selects.
// Operand 0 is id_rs (fwd_a), operand 1 is id_rt (fwd_b).
module hazard_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] ex_reg_address,
    input  logic       ex_write_reg,
    input  logic       ex_load,
    input  logic [4:0] mem_reg_address,
    input  logic       mem_write_reg,
    output logic       load_use,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    logic [4:0] src [2];
    logic [1:0] sel [2];
    logic [1:0] ex_hit;

    assign src[0] = id_rs;
    assign src[1] = id_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            logic ex_match;
            logic mem_match;

            assign ex_match  = reg_match(ex_reg_address, src[gi]);
            assign mem_match = reg_match(mem_reg_address, src[gi]);
            assign ex_hit[gi] = ex_match;

            // A load in EX has no result yet; that case is a stall, not a forward.
            assign sel[gi] = (ex_write_reg && !ex_load && ex_match) ? FWD_EX  :
                             (mem_write_reg && mem_match)           ? FWD_MEM :
                                                                      FWD_RF;
        end
    endgenerate

    assign load_use = ex_load && ex_write_reg && id_valid && (|ex_hit);
    assign fwd_a    = sel[0];
    assign fwd_b    = sel[1];

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the five-stage pipeline, with memory-wait freeze
// and timeout abort. Controls are Mealy-decoded; state, counters and the error flag are registered.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       ex_reg_address,
    input  logic             ex_write_reg,
    input  logic             ex_load,
    input  logic             ex_jump,
    input  logic [4:0]       mem_reg_address,
    input  logic             mem_write_reg,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_abort,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [7:0]       TIMEOUT_CNT = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    ctrl_state_e      state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_error_q, mem_error_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic       load_use;
    logic [1:0] fwd_a_c, fwd_b_c;

    logic pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c;
    logic bubble_c, flush_c, abort_c;

    hazard_fwd_unit u_hazard_fwd (
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .ex_reg_address  (ex_reg_address),
        .ex_write_reg    (ex_write_reg),
        .ex_load         (ex_load),
        .mem_reg_address (mem_reg_address),
        .mem_write_reg   (mem_write_reg),
        .load_use        (load_use),
        .fwd_a           (fwd_a_c),
        .fwd_b           (fwd_b_c)
    );

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_error_d = mem_error_q;
        pc_en_c     = 1'b1;
        if_id_en_c  = 1'b1;
        id_ex_en_c  = 1'b1;
        ex_mem_en_c = 1'b1;
        bubble_c    = 1'b0;
        flush_c     = 1'b0;
        abort_c     = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    pc_en_c     = 1'b0;
                    if_id_en_c  = 1'b0;
                    id_ex_en_c  = 1'b0;
                    ex_mem_en_c = 1'b0;
                    state_d     = MEM_WAIT;
                    wait_cnt_d  = 8'd1;
                end else if (ex_jump) begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                end else if (load_use) begin
                    pc_en_c    = 1'b0;
                    if_id_en_c = 1'b0;
                    bubble_c   = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else begin
                    pc_en_c     = 1'b0;
                    if_id_en_c  = 1'b0;
                    id_ex_en_c  = 1'b0;
                    ex_mem_en_c = 1'b0;
                    wait_cnt_d  = wait_cnt_q + 8'd1;
                    // wait_cnt counts stalled cycles including this one.
                    if (wait_cnt_d == TIMEOUT_CNT) begin
                        state_d    = ABORT;
                        wait_cnt_d = 8'd0;
                    end
                end
            end
            ABORT: begin
                abort_c     = 1'b1;
                bubble_c    = 1'b1;
                mem_error_d = 1'b1;
                state_d     = RUN;
                wait_cnt_d  = 8'd0;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end
        endcase

        stall_d = stall_q;
        if (!pc_en_c && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            mem_error_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
            stall_q     <= stall_d;
        end
    end

    // Every output is forced low while reset is held, independent of the inputs.
    assign pc_en        = !reset && pc_en_c;
    assign if_id_en     = !reset && if_id_en_c;
    assign id_ex_en     = !reset && id_ex_en_c;
    assign ex_mem_en    = !reset && ex_mem_en_c;
    assign id_ex_bubble = !reset && bubble_c;
    assign if_id_flush  = !reset && flush_c;
    assign mem_abort    = !reset && abort_c;
    assign mem_error    = !reset && mem_error_q;
    assign fwd_a        = reset ? FWD_RF : fwd_a_c;
    assign fwd_b        = reset ? FWD_RF : fwd_b_c;
    assign stall_cycles = reset ? '0 : stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus randomized check of pipeline_hazard_ctrl against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int TO        = 4;
    localparam int CW        = 6;
    localparam int STALL_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [4:0]    id_rs, id_rt, ex_reg_address, mem_reg_address;
    logic          ex_write_reg, ex_load, ex_jump, mem_write_reg, mem_req, mem_ready;
    logic          pc_en, if_id_en, id_ex_en, ex_mem_en, id_ex_bubble, if_id_flush;
    logic [1:0]    fwd_a, fwd_b;
    logic          mem_abort, mem_error;
    logic [CW-1:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    // Behavioural model: length of the current memory wait, pending abort, error and stall tally.
    int waited    = 0;
    bit abort_now = 0;
    bit err_m     = 0;
    int stall_m   = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .ex_reg_address  (ex_reg_address),
        .ex_write_reg    (ex_write_reg),
        .ex_load         (ex_load),
        .ex_jump         (ex_jump),
        .mem_reg_address (mem_reg_address),
        .mem_write_reg   (mem_write_reg),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .id_ex_bubble    (id_ex_bubble),
        .if_id_flush     (if_id_flush),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .mem_abort       (mem_abort),
        .mem_error       (mem_error),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; ex_reg_address = 0; mem_reg_address = 0;
        ex_write_reg = 0; ex_load = 0; ex_jump = 0; mem_write_reg = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] r);
        if (ex_write_reg && !ex_load && ex_reg_address != 0 && ex_reg_address == r) return 2'b01;
        if (mem_write_reg && mem_reg_address != 0 && mem_reg_address == r) return 2'b10;
        return 2'b00;
    endfunction

    // Inputs are applied just after a rising edge; outputs are checked at the falling edge.
    task automatic cycle(input string tag);
        logic [3:0] en;
        logic bub, fl, ab, lu;
        @(negedge clk);
        en = 4'hF; bub = 0; fl = 0; ab = 0;
        lu = ex_load && ex_write_reg && ex_reg_address != 0 && id_valid &&
             (ex_reg_address == id_rs || ex_reg_address == id_rt);
        if (abort_now) begin
            bub = 1; ab = 1;
        end else if (waited > 0) begin
            if (!mem_ready) en = 4'h0;
        end else if (mem_req && !mem_ready) begin
            en = 4'h0;
        end else if (ex_jump) begin
            fl = 1; bub = 1;
        end else if (lu) begin
            en = 4'b0011; bub = 1;
        end
        chk({tag, "/en"},     32'({pc_en, if_id_en, id_ex_en, ex_mem_en}), 32'(en));
        chk({tag, "/bubble"}, 32'(id_ex_bubble), 32'(bub));
        chk({tag, "/flush"},  32'(if_id_flush),  32'(fl));
        chk({tag, "/fwd_a"},  32'(fwd_a),        32'(fwd_ref(id_rs)));
        chk({tag, "/fwd_b"},  32'(fwd_b),        32'(fwd_ref(id_rt)));
        chk({tag, "/abort"},  32'(mem_abort),    32'(ab));
        chk({tag, "/error"},  32'(mem_error),    32'(err_m));
        chk({tag, "/stall"},  32'(stall_cycles), 32'(stall_m));
        $display("cycle %s: en=%b bub=%b fl=%b fa=%0d fb=%0d ab=%b err=%b stall=%0d",
                 tag, {pc_en, if_id_en, id_ex_en, ex_mem_en}, id_ex_bubble, if_id_flush,
                 fwd_a, fwd_b, mem_abort, mem_error, stall_cycles);
        if (en[3] == 1'b0 && stall_m < STALL_MAX) stall_m++;
        if (abort_now) begin
            abort_now = 0;
            err_m     = 1;
        end else if (waited > 0) begin
            if (mem_ready) begin
                waited = 0;
            end else begin
                waited++;
                if (waited == TO) begin
                    waited    = 0;
                    abort_now = 1;
                end
            end
        end else if (mem_req && !mem_ready) begin
            waited = 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        reset = 1;
        idle();
        #2;
        chk("rst/en",    32'({pc_en, if_id_en, id_ex_en, ex_mem_en}), 32'(0));
        chk("rst/stall", 32'(stall_cycles), 32'(0));
        chk("rst/error", 32'(mem_error), 32'(0));
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;

        // Load-use: one bubble, then EX holds the bubble.
        ex_load = 1; ex_write_reg = 1; ex_reg_address = 5; id_rs = 5; id_valid = 1;
        #1;
        chk("lu/pc_en", 32'(pc_en), 32'(0));
        cycle("lu");
        idle();
        cycle("lu_next");
        chk("lu/stall_total", 32'(stall_cycles), 32'(1));

        // Forwarding priority on operand B.
        ex_write_reg = 1; ex_reg_address = 3; mem_write_reg = 1; mem_reg_address = 3; id_rt = 3;
        #1;
        chk("fwd/ex", 32'(fwd_b), 32'(2'b01));
        cycle("fwd_ex");
        ex_write_reg = 0;
        #1;
        chk("fwd/mem", 32'(fwd_b), 32'(2'b10));
        cycle("fwd_mem");
        ex_write_reg = 1; ex_reg_address = 0; mem_reg_address = 0; id_rt = 0;
        #1;
        chk("fwd/zero", 32'(fwd_b), 32'(2'b00));
        cycle("fwd_zero");

        // Memory wait of three low cycles.
        idle();
        base = stall_m;
        mem_req = 1;
        repeat (3) cycle("mw");
        mem_ready = 1;
        #1;
        chk("mw/ready_pc_en", 32'(pc_en), 32'(1));
        cycle("mw_rdy");
        idle();
        cycle("mw_after");
        chk("mw/stall_delta", 32'(stall_cycles), 32'(base + 3));

        // Jump beats a simultaneous load-use.
        ex_jump = 1; ex_load = 1; ex_write_reg = 1; ex_reg_address = 7; id_rt = 7; id_valid = 1;
        #1;
        chk("jmp/flush", 32'(if_id_flush), 32'(1));
        chk("jmp/pc_en", 32'(pc_en), 32'(1));
        cycle("jmp");

        // Timeout: ready never rises.
        idle();
        base = stall_m;
        mem_req = 1;
        repeat (TO) cycle("to");
        mem_req = 0;
        #1;
        chk("to/abort", 32'(mem_abort), 32'(1));
        cycle("to_abort");
        chk("to/error_sticky", 32'(mem_error), 32'(1));
        chk("to/stall_delta", 32'(stall_cycles), 32'(base + TO));
        cycle("to_after");

        // Reset in the middle of a wait.
        mem_req = 1;
        cycle("rw0");
        cycle("rw1");
        reset = 1;
        #1;
        chk("rw/en",    32'({pc_en, if_id_en, id_ex_en, ex_mem_en}), 32'(0));
        chk("rw/abort", 32'(mem_abort), 32'(0));
        chk("rw/error", 32'(mem_error), 32'(0));
        waited = 0; abort_now = 0; err_m = 0; stall_m = 0;
        @(negedge clk);
        reset = 0;
        mem_req = 0;
        #1;
        chk("rw/stall_cleared", 32'(stall_cycles), 32'(0));
        chk("rw/error_cleared", 32'(mem_error), 32'(0));
        @(posedge clk);
        #1;
        cycle("rw_run");

        // Randomized traffic; stalls accumulate past the counter's saturation point.
        for (int i = 0; i < 400; i++) begin
            id_valid        = 1'($urandom_range(0, 1));
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_reg_address  = 5'($urandom_range(0, 3));
            mem_reg_address = 5'($urandom_range(0, 3));
            ex_write_reg    = 1'($urandom_range(0, 1));
            ex_load         = 1'($urandom_range(0, 1));
            ex_jump         = ($urandom_range(0, 4) == 0);
            mem_write_reg   = 1'($urandom_range(0, 1));
            mem_req         = ($urandom_range(0, 3) == 0);
            mem_ready       = ($urandom_range(0, 2) == 0);
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall, flush and forwarding controller for the five-stage MIPS pipeline.
- Each cycle it compares the decode-stage source registers against the destination fields held in the ID/EX and EX/MEM pipeline registers, and drives the pipeline-register enables, bubble-insert and flush controls.
- It also freezes the whole pipeline while a data-memory access is pending, with a timeout abort.
- It sits beside the pipeline registers and the PC; it owns no datapath storage.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum cycles of a single memory wait before the access is aborted (2..255).
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode stage holds a real instruction.
- id_rs, id_rt  in  5 each  decode-stage source register numbers.
- ex_reg_address  in  5  destination register of the instruction in EX.
- ex_write_reg, ex_load, ex_jump  in  1 each  EX-stage control bits; ex_jump means a jump/branch was taken, resolved in EX.
- mem_reg_address  in  5  destination register of the instruction in MEM.
- mem_write_reg  in  1  MEM-stage register write.
- mem_req  in  1  MEM stage is issuing a load or store.
- mem_ready  in  1  memory completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  enables for the PC and the pipeline registers.
- id_ex_bubble  out  1  ID/EX loads all-zero control (NOP).
- if_id_flush  out  1  IF/ID loads a NOP.
- fwd_a, fwd_b  out  2 each  operand source: 00 = register file, 01 = EX result, 10 = MEM result.
- mem_abort  out  1  one-cycle pulse when the memory wait times out.
- mem_error  out  1  sticky error flag; cleared only by reset.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en = 0.

## Operation
- States: RUN, MEM_WAIT, ABORT.
- Enables and controls are decoded combinationally from the current state and inputs (Mealy). State, counters and mem_error are registered.
- Priority in RUN: memory wait, then jump, then load-use.
- Memory wait (RUN):
  - Condition: mem_req=1 and mem_ready=0.
  - Same cycle: all four enables = 0.
  - Next state: MEM_WAIT; wait_cnt := 1.
- Jump (RUN, no memory wait):
  - if_id_flush=1, id_ex_bubble=1, all enables = 1.
  - State stays RUN.
- Load-use (RUN, none of the above):
  - Condition: ex_load, ex_write_reg, ex_reg_address≠0, id_valid, and ex_reg_address equals id_rs or id_rt.
  - pc_en=0, if_id_en=0, id_ex_en=1, id_ex_bubble=1, ex_mem_en=1.
  - Exactly one bubble per hazard.
- MEM_WAIT:
  - All enables = 0.
  - mem_ready=1: enables = 1 in that cycle, next state RUN.
  - Otherwise wait_cnt increments.
  - Timeout: when wait_cnt = MEM_TIMEOUT and mem_ready=0, next state is ABORT.
- ABORT (one cycle):
  - mem_abort=1; mem_error set.
  - All enables = 1; id_ex_bubble=1.
  - Next state RUN; wait_cnt := 0.
- Forwarding, per operand, with id_rs for fwd_a and id_rt for fwd_b:
  - 01 if ex_write_reg, !ex_load, ex_reg_address≠0 and the address matches.
  - Otherwise 10 if mem_write_reg, mem_reg_address≠0 and the address matches.
  - Otherwise 00.
  - Forwarding is evaluated in every state.
- stall_cycles increments on every cycle with pc_en=0 and holds at all-ones.

## Timing
- Reset (asynchronous, active-high) sets state RUN, wait_cnt 0, mem_error 0, stall_cycles 0.
- While reset=1, all outputs are forced to 0, including the enables, bubble, flush, fwd selects and mem_abort.
- Reset asserted mid-wait abandons the access without a mem_abort pulse.
- Hazard response latency is 0 cycles: controls are valid in the same cycle as the triggering inputs.
- Load-use costs exactly 1 stall cycle.
- A memory wait stalls for N cycles, where N is the number of cycles mem_ready is low, with N ≤ MEM_TIMEOUT.
- A timeout costs MEM_TIMEOUT stall cycles plus the ABORT cycle.
- ex_jump or a load-use arriving during MEM_WAIT is ignored. Because the pipeline is frozen, it is re-evaluated in the first RUN cycle.
- mem_ready in the same cycle as mem_req means no wait; the state stays RUN.
- Register 0 never triggers a hazard or a forward.

## Structure
- pipe_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, ABORT);
  - fwd select constants FWD_RF=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10;
  - the REG_ZERO constant.
- One combinational sub-module, hazard_fwd_unit, contains the register comparators, the load-use detect and the fwd_a/fwd_b muxing. The FSM and counters live in the top module.

## Test plan
- ex_load=1, ex_reg_address=5, id_rs=5, id_valid=1 -> one cycle with pc_en=0, if_id_en=0, id_ex_bubble=1; the next cycle all enables are 1; stall_cycles=1.
- ex_write_reg=1, ex_reg_address=3, mem_write_reg=1, mem_reg_address=3, id_rt=3 -> fwd_b=01; then with ex_write_reg=0 -> fwd_b=10; with both addresses 0 -> fwd_b=00.
- mem_req=1, mem_ready low for 3 cycles then high -> enables 0 for 3 cycles, 1 in the ready cycle; the state returns to RUN.
- MEM_TIMEOUT=4, mem_ready never rises -> mem_abort pulses once after 4 wait cycles; mem_error stays 1 afterwards; stall_cycles=4.
- ex_jump=1 with a simultaneous load-use match -> if_id_flush=1, id_ex_bubble=1, pc_en=1 (jump wins).
- Reset asserted during MEM_WAIT -> all outputs 0 immediately; after release, state RUN, mem_error=0, stall_cycles=0.
